// File: rtl/frame_stream_source.sv
// Raster-order frame reader: streams one frame from a single-port buffer
// as a valid/sop/eop pixel stream for the conv filter input.
module frame_stream_source #(
   parameter int PIX_WIDTH  = 24,
   parameter int ADDR_WIDTH = 20,
   parameter int DIM_WIDTH  = 16,
   parameter int RD_LATENCY = 2,
   parameter int MIN_DIM    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DIM_WIDTH-1:0]  img_width,
   input  logic [DIM_WIDTH-1:0]  img_heigth,
   input  logic                  ready,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [PIX_WIDTH-1:0]  mem_rd_data,
   output logic [PIX_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   output logic                  o_sop,
   output logic                  o_eop,
   output logic                  busy,
   output logic                  done,
   output logic                  err_size
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [DIM_WIDTH-1:0]  wid_q;
   logic [DIM_WIDTH-1:0]  hgt_q;
   logic [DIM_WIDTH-1:0]  col;
   logic [DIM_WIDTH-1:0]  row;
   logic                  rd_sop;
   logic                  rd_eop;
   logic [RD_LATENCY-1:0] tv;
   logic [RD_LATENCY-1:0] ts;
   logic [RD_LATENCY-1:0] te;

   logic                  col_end;
   logic                  last_rd;
   logic [DIM_WIDTH-1:0]  col_nx;
   logic [DIM_WIDTH-1:0]  row_nx;
   logic                  eop_nx;
   logic                  size_bad;

   always_comb begin
      col_end  = (col == wid_q - DIM_WIDTH'(1));
      last_rd  = col_end && (row == hgt_q - DIM_WIDTH'(1));
      col_nx   = col_end ? '0 : col + DIM_WIDTH'(1);
      row_nx   = col_end ? row + DIM_WIDTH'(1) : row;
      eop_nx   = (col_nx == wid_q - DIM_WIDTH'(1)) &&
                 (row_nx == hgt_q - DIM_WIDTH'(1));
      size_bad = (img_width < DIM_WIDTH'(MIN_DIM)) ||
                 (img_heigth < DIM_WIDTH'(MIN_DIM));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base_q    <= '0;
         wid_q     <= '0;
         hgt_q     <= '0;
         col       <= '0;
         row       <= '0;
         rd_sop    <= 1'b0;
         rd_eop    <= 1'b0;
         tv        <= '0;
         ts        <= '0;
         te        <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_sop     <= 1'b0;
         o_eop     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_size  <= 1'b0;
      end else if (clk_en) begin
         done     <= 1'b0;
         err_size <= 1'b0;
         // Tags ride alongside the read so they meet the returning data.
         tv[0] <= mem_rd_en;
         ts[0] <= mem_rd_en & rd_sop;
         te[0] <= mem_rd_en & rd_eop;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tv[i] <= tv[i-1];
            ts[i] <= ts[i-1];
            te[i] <= te[i-1];
         end
         o_valid <= tv[RD_LATENCY-1];
         o_sop   <= ts[RD_LATENCY-1];
         o_eop   <= te[RD_LATENCY-1];
         if (tv[RD_LATENCY-1]) o_data <= mem_rd_data;

         unique case (state)
            IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  wid_q  <= img_width;
                  hgt_q  <= img_heigth;
                  if (size_bad) begin
                     err_size <= 1'b1;
                  end else begin
                     state <= WAIT_RDY;
                     busy  <= 1'b1;
                  end
               end
            end
            WAIT_RDY: begin
               if (ready) begin
                  state     <= STREAM;
                  mem_rd_en <= 1'b1;
                  mem_addr  <= base_q;
                  col       <= '0;
                  row       <= '0;
                  rd_sop    <= 1'b1;
                  rd_eop    <= 1'b0;
               end
            end
            STREAM: begin
               rd_sop <= 1'b0;
               if (last_rd) begin
                  state     <= DRAIN;
                  mem_rd_en <= 1'b0;
                  rd_eop    <= 1'b0;
               end else begin
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
                  col      <= col_nx;
                  row      <= row_nx;
                  rd_eop   <= eop_nx;
               end
            end
            DRAIN: begin
               if (o_valid && o_eop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Hardware pixel-stream transmitter for the conv filter's input port.
- On a start pulse it reads one full frame from a single-port frame buffer in raster order. It emits the frame as a valid/sop/eop pixel stream matching conv's i_data/i_valid/i_sop/i_eop inputs.
- It waits for conv's ready before each frame and obeys the shared clk_en, so it can replace a software pixel driver in front of the per-channel conv instances.

Parameters:
- PIX_WIDTH, 24, pixel word width (3 x 8-bit RGB).
- ADDR_WIDTH, 20, frame-buffer word address width.
- DIM_WIDTH, 16, width of img_width / img_heigth.
- RD_LATENCY, 2, frame-buffer read latency in enabled cycles (legal range 1..4).
- MIN_DIM, 3, minimum legal width and height (kernel dimension).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  global clock enable; when 0 the block freezes
- start  in  1  one-cycle frame request pulse
- base_addr  in  ADDR_WIDTH  frame start address, sampled on accepted start
- img_width  in  DIM_WIDTH  pixels per row, sampled on accepted start
- img_heigth  in  DIM_WIDTH  rows per frame, sampled on accepted start
- ready  in  1  sink (conv) can accept a new frame
- mem_rd_en  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_WIDTH  frame-buffer read address
- mem_rd_data  in  PIX_WIDTH  read data, valid RD_LATENCY enabled cycles after mem_rd_en
- o_data  out  PIX_WIDTH  pixel
- o_valid  out  1  pixel valid
- o_sop  out  1  first pixel of frame (qualified by o_valid)
- o_eop  out  1  last pixel of frame (qualified by o_valid)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel emitted
- err_size  out  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (rst=1 at clk edge, regardless of clk_en): state IDLE; all outputs 0; read-tag pipeline cleared. Reset mid-frame aborts the frame with no eop.
- clk_en=0 freezes all state, counters and pipeline registers, and holds every output. The frame buffer's read port must be gated by the same clk_en. All cycle counts below are in enabled cycles.
- IDLE:
  - start=1: latch base_addr, img_width, img_heigth.
  - If width<MIN_DIM or height<MIN_DIM: pulse err_size and stay IDLE.
  - Otherwise go to WAIT_RDY; busy=1.
- WAIT_RDY: stay while ready=0; ready=1 moves to STREAM on the next cycle.
- STREAM:
  - mem_rd_en=1 every cycle; first mem_addr=base_addr.
  - Address increments by 1 per cycle, with no multiplier. col/row counters wrap col at width-1 and increment row.
  - Last read is at base_addr + width*height - 1 (modulo 2^ADDR_WIDTH, wrap allowed). After that read go to DRAIN with mem_rd_en=0.
- Tag pipeline: RD_LATENCY stages carrying {valid, sop, eop}.
  - sop is tagged on read (row 0, col 0); eop on read (height-1, width-1).
  - At the pipeline output, o_data<=mem_rd_data, o_valid<=tag.valid, o_sop<=tag.sop, o_eop<=tag.eop (registered).
  - The pixel for a read issued in cycle N appears on outputs in cycle N+RD_LATENCY+1.
  - o_valid is continuous for width*height cycles. o_sop and o_eop are each high exactly once per frame, never in the same cycle (MIN_DIM>=3).
- DRAIN:
  - After the cycle with o_eop=1, go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE. A start in the DONE cycle is ignored.
- start while not IDLE is ignored: no latch, no err_size.
- ready is checked only in WAIT_RDY; ready falling during STREAM does not stall the stream.
- o_data is don't-care when o_valid=0, but is held (not cleared) so it is stable in waveforms.
- Width rule: pixel count is width*height, computed via counters only.

Test Plan:
- Nominal frame: base_addr=0x100, 4x3, RD_LATENCY=2, ready=1, clk_en=1, memory word = address -> mem_addr 0x100..0x10B on 12 consecutive cycles. o_data 0x100..0x10B on 12 consecutive cycles starting 3 cycles after the first read. o_sop with 0x100, o_eop with 0x10B, done one cycle after eop, busy low after done.
- Ready hold-off: ready=0 for 20 cycles after start -> mem_rd_en stays 0 and busy=1. The first read occurs the cycle after ready rises.
- clk_en gating: clk_en toggled 1,0,1,0 during STREAM on a 5x5 frame -> output sequence identical to the nominal order, with no duplicated or dropped pixels. Outputs are held during clk_en=0 cycles; exactly 25 valid pixels.
- Size reject: start with width=2, height=8 -> err_size single pulse, busy stays 0, no mem_rd_en. The following start with 3x3 streams 9 pixels.
- Start while busy: second start mid-STREAM with different base_addr -> ignored, and the frame completes with the original addresses.
- Reset mid-frame: rst=1 after 7 of 12 pixels -> the next cycle has o_valid, o_eop, busy and mem_rd_en all 0. A fresh start then streams a full frame with o_sop on the first pixel.
